// File: rtl/gpio_ctrl_pkg.sv
// Shared register map and constants for the GPIO controller.
// Imported by the bus interface, the input/edge sub-block and the top level.
package gpio_ctrl_pkg;

    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef enum logic [ADDR_W-1:0] {
        REG_DOUT     = 3'd0,
        REG_DIR      = 3'd1,
        REG_DIN      = 3'd2,
        REG_EDGE_ST  = 3'd3,
        REG_EDGE_EN  = 3'd4,
        REG_POL      = 3'd5,
        REG_DOUT_SET = 3'd6,
        REG_DOUT_CLR = 3'd7
    } reg_addr_t;

    // Enabled cycles after reset during which edges are ignored, so pads that
    // are already high when reset lifts do not show up as rising edges.
    function automatic int prime_cycles(input int sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/gpio_ctrl_if.sv
// CPU data-memory bus port of the GPIO controller: one-cycle select, registered read data, level irq.
// Master drives the access, the controller (slave) returns rdata one cycle later; no backpressure.
interface gpio_ctrl_if #(
    parameter int WIDTH = 32
);

    logic                              cs;
    logic                              we;
    logic [gpio_ctrl_pkg::ADDR_W-1:0]  addr;
    logic [WIDTH-1:0]                  wdata;
    logic [WIDTH-1:0]                  rdata;
    logic                              irq;

    modport master (
        output cs, we, addr, wdata,
        input  rdata, irq
    );

    modport slave (
        input  cs, we, addr, wdata,
        output rdata, irq
    );

endinterface

// File: rtl/gpio_sync_edge.sv
// Pad synchroniser, previous-value flop, post-reset prime counter and polarity-selected edge detect.
// din lags the pads by SYNC_STAGES enabled cycles; ev is combinational from din/prev; never stalls.
module gpio_sync_edge
    import gpio_ctrl_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             clk_en,
    input  logic             rstb,
    input  logic [WIDTH-1:0] pad,
    input  logic [WIDTH-1:0] pol,
    output logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] ev
);

    localparam int PRIME = prime_cycles(SYNC_STAGES);
    localparam int CNT_W = $clog2(PRIME + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [CNT_W-1:0] prime_q;
    logic             primed;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (!rstb) begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= '0;
                end
                prev_q  <= '0;
                prime_q <= '0;
            end else begin
                sync_q[0] <= pad;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
                prev_q <= din;
                // Saturates once primed; only a reset rearms the suppression window.
                if (!primed) begin
                    prime_q <= prime_q + 1'b1;
                end
            end
        end
    end

    assign primed = (prime_q == CNT_W'(PRIME));
    assign din    = sync_q[SYNC_STAGES-1];
    assign rise   = din & ~prev_q;
    assign fall   = ~din & prev_q;
    assign ev     = primed ? ((pol & fall) | (~pol & rise)) : '0;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO: output/direction registers, synchronised inputs, per-bit edge capture, level irq.
// Reads return one cycle after select, writes land on the select edge; accesses never stall.
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RST_DOUT    = '0
) (
    input  logic             i_clk,
    input  logic             i_clk_en,
    input  logic             i_rstb,
    gpio_ctrl_if.slave       bus,
    inout  wire  [WIDTH-1:0] io_gpio
);

    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] edge_st_q;
    logic [WIDTH-1:0] edge_en_q;
    logic [WIDTH-1:0] pol_q;
    logic [WIDTH-1:0] rdata_q;
    logic             irq_q;

    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] w1c_mask;
    logic [WIDTH-1:0] rd_mux;
    logic             wr;
    logic             rd;
    reg_addr_t        addr;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (i_clk),
        .clk_en (i_clk_en),
        .rstb   (i_rstb),
        .pad    (io_gpio),
        .pol    (pol_q),
        .din    (din),
        .ev     (ev)
    );

    assign addr = reg_addr_t'(bus.addr);
    assign wr   = bus.cs & bus.we;
    assign rd   = bus.cs & ~bus.we;

    always_comb begin
        w1c_mask = '0;
        if (wr && addr == REG_EDGE_ST) begin
            w1c_mask = bus.wdata;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            REG_DOUT:    rd_mux = dout_q;
            REG_DIR:     rd_mux = dir_q;
            REG_DIN:     rd_mux = din;
            REG_EDGE_ST: rd_mux = edge_st_q;
            REG_EDGE_EN: rd_mux = edge_en_q;
            REG_POL:     rd_mux = pol_q;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clk_en) begin
            if (!i_rstb) begin
                dout_q    <= RST_DOUT;
                dir_q     <= '0;
                edge_st_q <= '0;
                edge_en_q <= '0;
                pol_q     <= '0;
                rdata_q   <= '0;
                irq_q     <= 1'b0;
            end else begin
                // A clear and a fresh event on the same bit: the event wins.
                edge_st_q <= (edge_st_q & ~w1c_mask) | ev;
                irq_q     <= |(edge_st_q & edge_en_q);
                if (rd) begin
                    rdata_q <= rd_mux;
                end
                if (wr) begin
                    case (addr)
                        REG_DOUT:     dout_q    <= bus.wdata;
                        REG_DIR:      dir_q     <= bus.wdata;
                        REG_EDGE_EN:  edge_en_q <= bus.wdata;
                        REG_POL:      pol_q     <= bus.wdata;
                        REG_DOUT_SET: dout_q    <= dout_q | bus.wdata;
                        REG_DOUT_CLR: dout_q    <= dout_q & ~bus.wdata;
                        default:      ;
                    endcase
                end
            end
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.irq   = irq_q;

    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
        assign io_gpio[g] = dir_q[g] ? dout_q[g] : 1'bz;
    end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: register table plus hand sequences for latency, irq, polarity,
// clock-enable hold and reset during an access.
module tb_gpio_ctrl;

    logic        i_clk;
    logic        i_clk_en;
    logic        i_rstb;
    logic [31:0] pad_drv;
    logic [31:0] pad_en;
    wire  [31:0] io_gpio;

    int tests;
    int fails;

    gpio_ctrl_if #(.WIDTH(32)) bus ();

    gpio_ctrl #(
        .WIDTH       (32),
        .SYNC_STAGES (2),
        .RST_DOUT    (32'h0)
    ) dut (
        .i_clk    (i_clk),
        .i_clk_en (i_clk_en),
        .i_rstb   (i_rstb),
        .bus      (bus),
        .io_gpio  (io_gpio)
    );

    for (genvar g = 0; g < 32; g++) begin : g_tb_pad
        assign io_gpio[g] = pad_en[g] ? pad_drv[g] : 1'bz;
    end

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] data;
        bit          chk_pad;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit wr, input logic [2:0] a, input logic [31:0] d,
                       input bit chk, input logic [31:0] e);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.chk_pad = chk; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        tick(1);
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] d);
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
        tick(1);
        bus.cs = 1'b0;
        d = bus.rdata;
    endtask

    initial begin
        logic [31:0] rd;
        tests = 0;
        fails = 0;
        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        i_clk_en = 1'b1;
        i_rstb   = 1'b0;
        pad_drv  = 32'hFFFF_FFFF;
        pad_en   = 32'hFFFF_FFFF;

        // Reset with pads held high.
        tick(4);
        check("rst_irq", {31'd0, bus.irq}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_pads_z", io_gpio, 32'hFFFF_FFFF);
        i_rstb = 1'b1;
        tick(6);
        do_read(3'd3, rd); check("no_false_edge", rd, 32'd0);
        do_read(3'd2, rd); check("din_high", rd, 32'hFFFF_FFFF);
        check("irq_after_rst", {31'd0, bus.irq}, 32'd0);
        pad_drv = 32'h0;
        tick(4);
        do_read(3'd3, rd); check("fall_ignored_pol0", rd, 32'd0);

        // Register table; the tb releases the low byte so the DUT can drive it.
        pad_en = 32'hFFFF_FF00;
        add(1, 3'd1, 32'h0000_00FF, 0, 32'h0);
        add(1, 3'd0, 32'hA5A5_A5A5, 1, 32'h0000_00A5);
        add(0, 3'd0, 32'h0,         0, 32'hA5A5_A5A5);
        add(0, 3'd1, 32'h0,         0, 32'h0000_00FF);
        add(1, 3'd6, 32'h0000_0F00, 1, 32'h0000_00A5);
        add(1, 3'd7, 32'h0000_00A5, 1, 32'h0000_0000);
        add(0, 3'd0, 32'h0,         0, 32'hA5A5_AF00);
        add(0, 3'd6, 32'h0,         0, 32'h0);
        add(0, 3'd7, 32'h0,         0, 32'h0);
        add(1, 3'd2, 32'h1234_5678, 0, 32'h0);
        add(0, 3'd2, 32'h0,         0, 32'h0);
        add(0, 3'd3, 32'h0,         0, 32'h0000_00A5);
        add(1, 3'd3, 32'h0000_00A0, 0, 32'h0);
        add(0, 3'd3, 32'h0,         0, 32'h0000_0005);
        add(1, 3'd3, 32'hFFFF_FFFF, 0, 32'h0);
        add(0, 3'd3, 32'h0,         0, 32'h0);
        add(1, 3'd4, 32'h0001_0000, 0, 32'h0);
        add(0, 3'd4, 32'h0,         0, 32'h0001_0000);
        add(1, 3'd5, 32'h0000_0008, 0, 32'h0);
        add(0, 3'd5, 32'h0,         0, 32'h0000_0008);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data);
                if (vecs[i].chk_pad) check($sformatf("vec%0d_pad", i), io_gpio, vecs[i].exp);
            end else begin
                do_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
            end
        end

        // Input latency and irq on pad 16.
        pad_drv[16] = 1'b1;
        do_read(3'd2, rd); check("din_lat_e1", rd, 32'h0);
        do_read(3'd2, rd); check("din_lat_e2", rd, 32'h0);
        do_read(3'd2, rd); check("din_lat_e3", rd, 32'h0001_0000);
        check("irq_before_cap", {31'd0, bus.irq}, 32'd0);
        do_read(3'd3, rd); check("edge_st_16", rd, 32'h0001_0000);
        check("irq_set", {31'd0, bus.irq}, 32'd1);
        do_write(3'd3, 32'h0001_0000);
        check("irq_hold_on_clr", {31'd0, bus.irq}, 32'd1);
        tick(1);
        check("irq_cleared", {31'd0, bus.irq}, 32'd0);

        // Edge arriving on the same cycle as its clear.
        pad_drv[16] = 1'b0;
        tick(4);
        check("irq_fall_pol0", {31'd0, bus.irq}, 32'd0);
        pad_drv[16] = 1'b1;
        tick(2);
        do_write(3'd3, 32'h0001_0000);
        do_read(3'd3, rd); check("ev_beats_clr", rd, 32'h0001_0000);
        check("irq_ev_beats_clr", {31'd0, bus.irq}, 32'd1);
        do_write(3'd3, 32'h0001_0000);
        tick(1);
        do_read(3'd3, rd); check("clr_again", rd, 32'h0);
        check("irq_clr_again", {31'd0, bus.irq}, 32'd0);

        // Falling polarity on pad 3, driven by the DUT and read back through the pad.
        do_write(3'd6, 32'h0000_0008);
        tick(4);
        do_read(3'd3, rd); check("pol_rise_ignored", rd, 32'h0);
        do_write(3'd7, 32'h0000_0008);
        tick(4);
        do_read(3'd3, rd); check("pol_fall_cap", rd, 32'h0000_0008);
        do_write(3'd3, 32'h0000_0008);
        do_write(3'd6, 32'h0000_0008);
        tick(4);
        do_read(3'd3, rd); check("pol_single_cap", rd, 32'h0);
        check("pol_pads", io_gpio, 32'h0001_0008);
        check("pol_irq", {31'd0, bus.irq}, 32'd0);

        // Clock enable low: accesses dropped, pad toggles unseen.
        do_read(3'd0, rd); check("dout_pre_hold", rd, 32'hA5A5_AF08);
        i_clk_en = 1'b0;
        do_write(3'd0, 32'hDEAD_BEEF);
        pad_drv[16] = 1'b0;
        tick(3);
        do_read(3'd1, rd);
        check("rdata_hold", rd, 32'hA5A5_AF08);
        pad_drv[16] = 1'b1;
        tick(5);
        check("hold_pads", io_gpio, 32'h0001_0008);
        check("hold_irq", {31'd0, bus.irq}, 32'd0);
        i_clk_en = 1'b1;
        do_read(3'd0, rd); check("dout_after_hold", rd, 32'hA5A5_AF08);
        do_read(3'd3, rd); check("no_cap_in_hold", rd, 32'h0);

        // Reset during a read and a write.
        pad_drv = 32'h0001_0008;
        pad_en  = 32'hFFFF_FFFF;
        i_rstb  = 1'b0;
        do_read(3'd0, rd); check("rst_mid_read", rd, 32'h0);
        do_write(3'd0, 32'h1234_5678);
        tick(2);
        check("rst_pads_z2", io_gpio, 32'h0001_0008);
        i_rstb = 1'b1;
        tick(1);
        do_read(3'd0, rd); check("rst_no_write", rd, 32'h0);
        do_read(3'd1, rd); check("rst_dir", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
